// File: rtl/pipe_muldiv_if.sv
// Handshake bundle between the execute stage and the multiply/divide unit.
interface pipe_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [4:0]      rd_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start_i, op_i, a_i, b_i, rd_i, flush_i,
        input  busy_o, stall_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, rd_i, flush_i,
        output busy_o, stall_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/pipe_muldiv_unit.sv
// RV32M/RV64M multiply/divide unit for the execute stage.
// Fixed-latency multiply, iterative restoring divide, one op in flight.
module pipe_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_UNROLL = 1
) (
    input  logic          clk,
    input  logic          rst,
    pipe_muldiv_if.slave  bus
);
    localparam int NIT = XLEN / DIV_UNROLL;
    localparam int CW  = $clog2(NIT) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(NIT - 1);
    localparam logic [CW-1:0] MUL_LAST =
        CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] res_q;
    logic [4:0]      rd_q;
    logic [4:0]      tag_q;
    logic [XLEN-1:0] mul_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_q;
    logic [CW-1:0]   cnt_q;
    logic            fix_q;
    logic            negq_q;
    logic            negr_q;
    logic            isrem_q;

    logic            idle_like;
    logic            can_start;
    logic            div_sgn;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] spec_res;
    logic [XLEN:0]   ax;
    logic [XLEN:0]   bx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mul_sel;
    logic [XLEN:0]   rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign idle_like = (state_q == S_IDLE) | (state_q == S_DONE);
    assign can_start = idle_like & bus.start_i & ~bus.flush_i;

    // Operand conditioning for the divider
    assign div_sgn  = ~bus.op_i[0];
    assign sa       = div_sgn & bus.a_i[XLEN-1];
    assign sb       = div_sgn & bus.b_i[XLEN-1];
    assign a_mag    = sa ? -bus.a_i : bus.a_i;
    assign b_mag    = sb ? -bus.b_i : bus.b_i;
    assign div_zero = (bus.b_i == '0);
    assign div_ovf  = div_sgn
                    & (bus.a_i == {1'b1, {(XLEN-1){1'b0}}})
                    & (bus.b_i == '1);

    always_comb begin
        spec_res = '0;
        if (div_zero) begin
            spec_res = bus.op_i[1] ? bus.a_i : '1;
        end else begin
            spec_res = bus.op_i[1] ? '0 : bus.a_i;
        end
    end

    // MULH treats both operands signed, MULHSU only a
    assign ax = {(bus.op_i[1:0] == 2'b01) | (bus.op_i[1:0] == 2'b10)
                 ? bus.a_i[XLEN-1] : 1'b0, bus.a_i};
    assign bx = {(bus.op_i[1:0] == 2'b01) ? bus.b_i[XLEN-1] : 1'b0,
                 bus.b_i};
    assign prod = {{(XLEN-1){ax[XLEN]}}, ax}
                * {{(XLEN-1){bx[XLEN]}}, bx};
    assign mul_sel = (bus.op_i[1:0] == 2'b00)
                   ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        for (int i = 0; i < DIV_UNROLL; i++) begin
            rem_d = {rem_d[XLEN-1:0], quo_d[XLEN-1]};
            quo_d = {quo_d[XLEN-2:0], 1'b0};
            if (rem_d >= {1'b0, dvs_q}) begin
                rem_d    = rem_d - {1'b0, dvs_q};
                quo_d[0] = 1'b1;
            end
        end
    end

    assign quo_fix = negq_q ? -quo_q : quo_q;
    assign rem_fix = negr_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            tag_q   <= '0;
            mul_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            fix_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isrem_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (can_start) begin
                        tag_q <= bus.rd_i;
                        cnt_q <= '0;
                        if (!bus.op_i[2]) begin
                            mul_q <= mul_sel;
                            if (MUL_STAGES == 1) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                res_q   <= mul_sel;
                                rd_q    <= bus.rd_i;
                            end else begin
                                state_q <= S_MUL;
                                busy_q  <= 1'b1;
                            end
                        end else if (div_zero | div_ovf) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            res_q   <= spec_res;
                            rd_q    <= bus.rd_i;
                        end else begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            dvs_q   <= b_mag;
                            negq_q  <= sa ^ sb;
                            negr_q  <= sa;
                            isrem_q <= bus.op_i[1];
                            fix_q   <= 1'b0;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == MUL_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= mul_q;
                        rd_q    <= tag_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DIV: begin
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (fix_q) begin
                        // Restore result signs after the unsigned loop
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= isrem_q ? rem_fix : quo_fix;
                        rd_q    <= tag_q;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == DIV_LAST) begin
                            fix_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.stall_o  = (bus.start_i & ~idle_like) | busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = res_q;
    assign bus.rd_o     = rd_q;
endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Directed plus randomized check of pipe_muldiv_unit against
// an arithmetic reference model.
module tb_pipe_muldiv_unit;
    localparam int XLEN = 32;
    localparam int MS   = 2;
    localparam int DU   = 1;
    localparam int DLAT = XLEN / DU + 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] last_exp;

    pipe_muldiv_if #(.XLEN(XLEN)) bus ();

    pipe_muldiv_unit #(
        .XLEN(XLEN),
        .MUL_STAGES(MS),
        .DIV_UNROLL(DU)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            assert (!(bus.start_i && bus.busy_o))
            else begin
                bad++;
                $error("FAIL start_busy obs=1 exp=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (!op[2]) return MS;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DLAT;
    endfunction

    task automatic launch(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.rd_i    = rd;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done_o !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        launch(op, a, b, rd);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, a, b)));
        chk({tag, "_res"}, 64'(bus.result_o), 64'(exp));
        chk({tag, "_rd"}, 64'(bus.rd_o), 64'(rd));
        last_exp = exp;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.done_o), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        total = 0;
        bad = 0;
        last_exp = '0;
        rst = 1'b0;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i = '0;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.rd_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_res", 64'(bus.result_o), 64'd0);
        chk("rst_rd", 64'(bus.rd_o), 64'd0);
        rst = 1'b1;

        do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
        do_op("mulhu", 3'd3, '1, '1, 5'd4, 32'hFFFF_FFFE);
        do_op("mulh", 3'd1, '1, '1, 5'd5, 32'h0);
        do_op("mulhsu", 3'd2, '1, '1, 5'd6, 32'hFFFF_FFFF);
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
        do_op("divu0", 3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
        do_op("removf", 3'd6, 32'h8000_0000, '1, 5'd10, 32'h0);
        do_op("divovf", 3'd4, 32'h8000_0000, '1, 5'd11, 32'h8000_0000);
        do_op("remu", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2);

        // Stall behaviour: idle start does not stall, busy does
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i = 3'd5;
        bus.a_i = 32'd9;
        bus.b_i = 32'd4;
        bus.rd_i = 5'd13;
        #1;
        chk("stall_idle", 64'(bus.stall_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("stall_busy", 64'(bus.stall_o), 64'd1);
        repeat (8) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_busy", 64'(bus.busy_o), 64'd0);
        chk("flush_done", 64'(bus.done_o), 64'd0);
        chk("flush_res", 64'(bus.result_o), 64'(last_exp));
        do_op("mul_aft", 3'd0, 32'd12, 32'd11, 5'd14, 32'd132);

        // Reset in the middle of a divide
        @(negedge clk);
        launch(3'd4, 32'd1000, 32'd3, 5'd15);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 64'(bus.busy_o), 64'd0);
        chk("mrst_stall", 64'(bus.stall_o), 64'd0);
        chk("mrst_done", 64'(bus.done_o), 64'd0);
        chk("mrst_res", 64'(bus.result_o), 64'd0);
        chk("mrst_rd", 64'(bus.rd_o), 64'd0);
        rst = 1'b1;

        // Back-to-back multiplies, second started in the DONE cycle
        @(negedge clk);
        launch(3'd0, 32'd6, 32'd7, 5'd16);
        wait_done(lat);
        chk("b2b1_res", 64'(bus.result_o), 64'd42);
        launch(3'd3, 32'h8000_0000, 32'd4, 5'd17);
        wait_done(lat);
        chk("b2b2_lat", 64'(lat), 64'(MS));
        chk("b2b2_res", 64'(bus.result_o), 64'd2);
        chk("b2b2_rd", 64'(bus.rd_o), 64'd17);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom_range(0, 31));
            do_op("rnd", op, a, b, rd, ref_res(op, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
